// File: rtl/soc_trace_arbiter.sv
// Merges per-core trace events into one valid/ready stream and raises all_terminated once every core
// has terminated and the stream has drained. Defining SOC_TRACE_ARB_STALL_EN adds the core_stall output.
module soc_trace_arbiter #(
  parameter int NUM_CORES      = 4,
  parameter int PC_WIDTH       = 32,
  parameter int INSN_WIDTH     = 32,
  parameter int DROP_CNT_WIDTH = 16,
  parameter int ID_WIDTH       = $clog2(NUM_CORES)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CORES-1:0]                trace_valid,
  input  logic [NUM_CORES*PC_WIDTH-1:0]       trace_pc,
  input  logic [NUM_CORES*INSN_WIDTH-1:0]     trace_insn,
  input  logic [NUM_CORES-1:0]                termination,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ID_WIDTH-1:0]                 out_id,
  output logic [PC_WIDTH-1:0]                 out_pc,
  output logic [INSN_WIDTH-1:0]               out_insn,
  output logic [NUM_CORES*DROP_CNT_WIDTH-1:0] drop_cnt,
  output logic                                all_terminated
`ifdef SOC_TRACE_ARB_STALL_EN
  ,
  output logic [NUM_CORES-1:0]                core_stall
`endif
);

  // state    | meaning
  // ST_RUN   | collecting sticky termination flags
  // ST_DRAIN | all cores terminated, waiting for buffers and output stage to empty
  // ST_DONE  | all_terminated asserted until reset
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [NUM_CORES-1:0]      hold_valid;
  logic [NUM_CORES-1:0]      hold_valid_nxt;
  logic [PC_WIDTH-1:0]       hold_pc   [NUM_CORES];
  logic [INSN_WIDTH-1:0]     hold_insn [NUM_CORES];
  logic [DROP_CNT_WIDTH-1:0] drop_q    [NUM_CORES];
  logic [NUM_CORES-1:0]      term_flag;
  logic [ID_WIDTH-1:0]       rr_ptr;

  logic                      advance;
  logic                      gnt_found;
  logic [ID_WIDTH-1:0]       gnt_idx;
  logic [NUM_CORES-1:0]      gnt_vec;
  logic [NUM_CORES-1:0]      accept;
  logic [NUM_CORES-1:0]      load;
  logic [NUM_CORES-1:0]      drop;

  assign advance = ~out_valid | out_ready;
  assign accept  = trace_valid & ~term_flag;

  // Cyclic search starting just after rr_ptr: higher indices first, then wrap to the low ones.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!gnt_found && hold_valid[i] && (ID_WIDTH'(i) > rr_ptr)) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_WIDTH'(i);
      end
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!gnt_found && hold_valid[i] && (ID_WIDTH'(i) <= rr_ptr)) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_WIDTH'(i);
      end
    end
  end

  always_comb begin
    gnt_vec = '0;
    if (advance && gnt_found) begin
      gnt_vec[gnt_idx] = 1'b1;
    end
  end

  assign load           = accept & (~hold_valid | gnt_vec);
  assign drop           = accept & hold_valid & ~gnt_vec;
  assign hold_valid_nxt = load | (hold_valid & ~gnt_vec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        hold_pc[i]   <= '0;
        hold_insn[i] <= '0;
      end
    end else begin
      hold_valid <= hold_valid_nxt;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (load[i]) begin
          hold_pc[i]   <= trace_pc[i*PC_WIDTH +: PC_WIDTH];
          hold_insn[i] <= trace_insn[i*INSN_WIDTH +: INSN_WIDTH];
        end
      end
    end
  end

  // Output register only moves when empty or being accepted, which keeps data stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_pc    <= '0;
      out_insn  <= '0;
      rr_ptr    <= ID_WIDTH'(NUM_CORES - 1);
    end else if (advance) begin
      out_valid <= gnt_found;
      if (gnt_found) begin
        out_id   <= gnt_idx;
        out_pc   <= hold_pc[gnt_idx];
        out_insn <= hold_insn[gnt_idx];
        rr_ptr   <= gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        drop_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (drop[i] && !(&drop_q[i])) begin
          drop_q[i] <= drop_q[i] + DROP_CNT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      drop_cnt[i*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] = drop_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      term_flag <= '0;
      state     <= ST_RUN;
    end else begin
      term_flag <= term_flag | termination;
      state     <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN:   if (&term_flag) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!(|hold_valid) && !out_valid) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_DONE;
      default:  state_nxt = ST_RUN;
    endcase
  end

  assign all_terminated = (state == ST_DONE);

`ifdef SOC_TRACE_ARB_STALL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_stall <= '0;
    end else begin
      core_stall <= hold_valid_nxt;
    end
  end
`endif

endmodule
